// File: rtl/key_expansion_aes.sv
// AES-128 key expansion: one S-box lookup per cycle, all 11 round keys stored, 1-cycle registered read.
// Optional KEY_EXP_REVERSE_EN adds en_de, which reverses the read index for decryption.
module key_expansion_aes #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load_in,
  input  logic [3:0]   round_in,
`ifdef KEY_EXP_REVERSE_EN
  input  logic         en_de,
`endif
  output logic [127:0] key_out,
  output logic         ready_out,
  output logic         busy_out
);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x lives at bit offset (255-x)*8, i.e. {~x, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       state;
  logic [127:0] rk [0:NR];
  logic [3:0]   rnd;
  logic [1:0]   bc;
  logic [7:0]   rcon;
  logic [31:0]  sub_word;

  logic [127:0] prev_rk;
  logic [31:0]  rot_w, t, w0n, w1n, w2n, w3n;
  logic [7:0]   sbox_in, sbox_out;

  assign prev_rk  = rk[rnd - 4'd1];
  assign rot_w    = {prev_rk[23:0], prev_rk[31:24]};
  // Byte 0 is the most significant byte of the word.
  assign sbox_in  = rot_w[{~bc, 3'b000} +: 8];
  assign sbox_out = sbox(sbox_in);
  assign t        = sub_word ^ {rcon, 24'h0};
  assign w0n      = prev_rk[127:96] ^ t;
  assign w1n      = prev_rk[95:64]  ^ w0n;
  assign w2n      = prev_rk[63:32]  ^ w1n;
  assign w3n      = prev_rk[31:0]   ^ w2n;

  logic       rd_ok;
  logic [3:0] rd_idx;
  assign rd_ok = (round_in <= 4'(NR));
`ifdef KEY_EXP_REVERSE_EN
  assign rd_idx = en_de ? (4'(NR) - round_in) : round_in;
`else
  assign rd_idx = round_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
      key_out   <= '0;
      ready_out <= 1'b0;
      busy_out  <= 1'b0;
      rnd       <= 4'd1;
      bc        <= 2'd0;
      rcon      <= 8'h01;
      sub_word  <= '0;
    end else begin
      key_out <= (ready_out && rd_ok) ? rk[rd_idx] : '0;
      // A load wins over everything and restarts expansion from the new key.
      if (key_load_in) begin
        rk[0]     <= key_in;
        ready_out <= 1'b0;
        busy_out  <= 1'b1;
        rnd       <= 4'd1;
        bc        <= 2'd0;
        rcon      <= 8'h01;
        state     <= SUB;
      end else begin
        case (state)
          SUB: begin
            sub_word[{~bc, 3'b000} +: 8] <= sbox_out;
            bc <= bc + 2'd1;
            if (bc == 2'd3) state <= MIX;
          end
          MIX: begin
            rk[rnd] <= {w0n, w1n, w2n, w3n};
            rcon    <= xtime(rcon);
            if (rnd == 4'(NR)) begin
              state     <= DONE;
              ready_out <= 1'b1;
              busy_out  <= 1'b0;
            end else begin
              rnd   <= rnd + 4'd1;
              state <= SUB;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_aes.sv
// Bench for key_expansion_aes: FIPS-197 vectors plus random keys checked against a GF(2^8)-derived model.
module tb_key_expansion_aes;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load_in = 1'b0;
  logic [3:0]   round_in = '0;
  logic [127:0] key_out;
  logic         ready_out, busy_out;
`ifdef KEY_EXP_REVERSE_EN
  logic         en_de = 1'b0;
`endif

  key_expansion_aes dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load_in(key_load_in),
    .round_in(round_in),
`ifdef KEY_EXP_REVERSE_EN
    .en_de(en_de),
`endif
    .key_out(key_out), .ready_out(ready_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [127:0] exp_rk [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box = multiplicative inverse (x^254) followed by the AES affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_load(input logic [127:0] key);
    key_in = key;
    key_load_in = 1'b1;
    tick();
    key_load_in = 1'b0;
    key_in = rand_key();
  endtask

  // Edges after the load edge until ready_out is seen; the load edge itself is the first of 51.
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!ready_out && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++; if (key_out !== 128'h0) $display("FAIL reset_key_out: got %h want 0", key_out); else pass_cnt++;
    chk_cnt++; if (ready_out !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_out); else pass_cnt++;
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      key_in = rand_key();
      round_in = 4'($urandom_range(0, 15));
      tick();
      if (ready_out !== 1'b0 || busy_out !== 1'b0 || key_out !== 128'h0) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL idle_no_change: got %0d nonzero cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_fips();
    int n;
    model_expand(FIPS_KEY);
    round_in = 4'd0;
    do_load(FIPS_KEY);
    chk_cnt++;
    if (busy_out !== 1'b1 || ready_out !== 1'b0 || key_out !== 128'h0)
      $display("FAIL fips_busy: got busy=%b ready=%b key=%h want 1 0 0", busy_out, ready_out, key_out);
    else pass_cnt++;
    wait_ready(n);
    chk_cnt++; if (n != 50) $display("FAIL fips_ready_edge: got %0d want 50", n); else pass_cnt++;
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL fips_busy_done: got %b want 0", busy_out); else pass_cnt++;
    round_in = 4'd0; tick();
    chk_cnt++; if (key_out !== FIPS_KEY) $display("FAIL fips_rk0: got %h want %h", key_out, FIPS_KEY); else pass_cnt++;
    round_in = 4'd1; tick();
    chk_cnt++; if (key_out !== FIPS_RK1) $display("FAIL fips_rk1: got %h want %h", key_out, FIPS_RK1); else pass_cnt++;
    round_in = 4'd10; tick();
    chk_cnt++; if (key_out !== FIPS_RK10) $display("FAIL fips_rk10: got %h want %h", key_out, FIPS_RK10); else pass_cnt++;
    for (int r = 0; r <= 10; r++) begin
      round_in = 4'(r); tick();
      chk_cnt++;
      if (key_out !== exp_rk[r]) $display("FAIL fips_model_rk%0d: got %h want %h", r, key_out, exp_rk[r]);
      else pass_cnt++;
    end
  endtask

  task automatic test_out_of_range();
    logic [127:0] want;
    round_in = 4'd11; tick();
    chk_cnt++; if (key_out !== 128'h0) $display("FAIL oor_11: got %h want 0", key_out); else pass_cnt++;
    round_in = 4'd15; tick();
    chk_cnt++; if (key_out !== 128'h0) $display("FAIL oor_15: got %h want 0", key_out); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      int r = $urandom_range(0, 15);
      round_in = 4'(r);
      tick();
      want = (r <= 10) ? exp_rk[r] : 128'h0;
      chk_cnt++;
      if (key_out !== want) $display("FAIL track_r%0d: got %h want %h", r, key_out, want);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_keys();
    int n;
    for (int k = 0; k < 3; k++) begin
      logic [127:0] key = rand_key();
      model_expand(key);
      do_load(key);
      wait_ready(n);
      chk_cnt++; if (n != 50) $display("FAIL rand%0d_ready_edge: got %0d want 50", k, n); else pass_cnt++;
      for (int r = 0; r <= 10; r++) begin
        round_in = 4'(r); tick();
        chk_cnt++;
        if (key_out !== exp_rk[r]) $display("FAIL rand%0d_rk%0d: got %h want %h", k, r, key_out, exp_rk[r]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reload();
    int n;
    do_load(rand_key());
    for (int i = 0; i < 19; i++) tick();
    chk_cnt++;
    if (ready_out !== 1'b0 || busy_out !== 1'b1)
      $display("FAIL reload_mid: got ready=%b busy=%b want 0 1", ready_out, busy_out);
    else pass_cnt++;
    do_load(FIPS_KEY);
    wait_ready(n);
    chk_cnt++; if (n != 50) $display("FAIL reload_ready_edge: got %0d want 50", n); else pass_cnt++;
    round_in = 4'd10; tick();
    chk_cnt++; if (key_out !== FIPS_RK10) $display("FAIL reload_rk10: got %h want %h", key_out, FIPS_RK10); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    round_in = 4'd0;
    do_load(rand_key());
    for (int i = 0; i < 29; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_cnt++; if (key_out !== 128'h0) $display("FAIL rstmid_key_out: got %h want 0", key_out); else pass_cnt++;
    chk_cnt++; if (ready_out !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", ready_out); else pass_cnt++;
    chk_cnt++; if (busy_out !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_out); else pass_cnt++;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ready_out !== 1'b0 || busy_out !== 1'b0 || key_out !== 128'h0) bad++;
    end
    chk_cnt++; if (bad != 0) $display("FAIL rstmid_stays_idle: got %0d active cycles want 0", bad); else pass_cnt++;
  endtask

`ifdef KEY_EXP_REVERSE_EN
  task automatic test_reverse();
    int n;
    model_expand(FIPS_KEY);
    do_load(FIPS_KEY);
    wait_ready(n);
    en_de = 1'b1;
    round_in = 4'd0; tick();
    chk_cnt++; if (key_out !== FIPS_RK10) $display("FAIL rev_r0: got %h want %h", key_out, FIPS_RK10); else pass_cnt++;
    round_in = 4'd10; tick();
    chk_cnt++; if (key_out !== FIPS_KEY) $display("FAIL rev_r10: got %h want %h", key_out, FIPS_KEY); else pass_cnt++;
    round_in = 4'd3; tick();
    chk_cnt++; if (key_out !== exp_rk[7]) $display("FAIL rev_r3: got %h want %h", key_out, exp_rk[7]); else pass_cnt++;
    round_in = 4'd12; tick();
    chk_cnt++; if (key_out !== 128'h0) $display("FAIL rev_r12: got %h want 0", key_out); else pass_cnt++;
    en_de = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_out_of_range();
    test_random_keys();
    test_reload();
    test_reset_mid();
`ifdef KEY_EXP_REVERSE_EN
    test_reverse();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
